demux_deser_4ch: RTL and testbench
==================================

# demux_deser_4ch

Four-channel bit-serial word assembler that sits directly downstream of the 1:4 demultiplexer. It samples the demux outputs y0..y3 with the same select lines s1/s0 that steer the demux, and shifts each channel's bits into its own deserializer. Completed words go to per-channel hold registers. A single arbiter then drains those hold registers onto one valid/ready word output.

## Interface

Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..16

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset: asynchronous, active-low
- bit_valid  input  1  the demux carries a valid data bit this cycle
- s0  input  1  demux select LSB, identical to the demux's s0
- s1  input  1  demux select MSB, identical to the demux's s1
- y0, y1, y2, y3  input  1 each  demux outputs
- word_valid  output  1  output word is available
- word_ready  input  1  consumer accepts the word
- word_ch  output  2  source channel of word_data
- word_data  output  WIDTH  assembled word, first-received bit in the MSB
- ovf  output  4  sticky per-channel overflow flags
- clr_ovf  input  1  synchronous clear of all ovf bits

## Operation

- Channel select: c = {s1,s0}; the input bit is y_c. The other three y lines are ignored.
- When bit_valid=1: shreg[c] <= {shreg[c][WIDTH-2:0], y_c} and cnt[c] increments. Only channel c changes.
- Word completion: when bit_valid=1 and cnt[c]==WIDTH-1, the word {shreg[c][WIDTH-2:0], y_c} is offered to hold[c], and cnt[c] wraps to 0.
  - If full[c]=0, or hold[c] is drained on the same edge: hold[c] <= word and full[c] <= 1.
  - Otherwise the word is dropped, hold[c] keeps its old content, and ovf[c] <= 1.
- Output register:
  - It is free when word_valid=0, or when word_valid=1 and word_ready=1 (the word is accepted this edge).
  - When it is free and any full[] bit is set, the arbiter grants one channel g: word_data <= hold[g], word_ch <= g, word_valid <= 1, full[g] <= 0.
  - When it is free and no full[] bit is set, word_valid <= 0.
- Stability: while word_valid=1 and word_ready=0, word_data and word_ch hold steady.
- ovf: clr_ovf=1 clears all four bits. If an overflow occurs on the same edge, the set wins for that bit.
- Reset (rst_n=0, asynchronous, mid-word included): cnt, shreg, hold, full, ovf, and the arbiter pointer go to 0. Outputs reset to word_valid=0, word_data=0, word_ch=0, ovf=4'b0000. Partial words are discarded.

## Timing

- The last bit of a word is sampled at edge N. full[c] is 1 after edge N.
- If the output register is free, word_valid rises after edge N+1. Minimum latency is 2 edges from the final bit's cycle to word_valid.
- Throughput: one word per cycle on the output when word_ready is held at 1.
- Bit input has no backpressure. bit_valid may be high every cycle, on any mix of channels.
- Same-edge events:
  - Drain and completion on the same channel: the new word is stored and full stays 1. This is not an overflow.
  - Completions on several channels in one cycle cannot happen, because only one channel is selected per cycle.
- No combinational path exists from word_ready to word_valid, word_data or word_ch.

## Configuration

- DEMUX_DESER_RR_EN defined: round-robin arbitration. The search starts at the channel after the last grant, wrapping 3→0. The pointer resets to 0, so ch0 is checked first after reset.
- DEMUX_DESER_RR_EN undefined: fixed priority, ch0 highest and ch3 lowest. There is no pointer state.

## Test plan

- Single word, WIDTH=8, word_ready=1: send 0xA5 MSB-first on channel 2 ({s1,s0}=2'b10) with bit_valid=1 for 8 cycles. Expect exactly one word_valid pulse, 2 edges after the last bit, with word_ch=2 and word_data=0xA5.
- Interleaving: alternate channel 0 and channel 1 bit by bit, carrying 0x3C on ch0 and 0xC3 on ch1. Expect word ch0=0x3C, then ch1=0xC3, in completion order, and ovf=0.
- Backpressure and overflow: hold word_ready=0 and send 0x11, 0x22, 0x33 on ch3. Expect word_data=0x11 held steady and ovf[3]=1 after 0x33 completes. Then set word_ready=1 and expect 0x11, then 0x22; 0x33 is never output.
- Arbitration: fill hold[0..3] with 0x10..0x13 while word_ready=0, then release.
  - With DEMUX_DESER_RR_EN: output order is ch0, ch1, ch2, ch3. Refilling ch0 right after its grant still puts it behind ch1..ch3.
  - Without it: a refilled ch0 always wins next.
- Reset mid-word: after 5 bits on ch1, pulse rst_n low for one half-cycle asynchronously. Expect all outputs 0 immediately. A following 8-bit 0x5A on ch1 must produce exactly 0x5A.
- ovf clear race: with ovf[0]=1, assert clr_ovf on the same cycle as a fresh ch0 overflow. Expect ovf[0]=1. Then assert clr_ovf alone and expect ovf=4'b0000.

Source files
------------

// File: rtl/demux_deser_4ch.sv
// ---------------------------------------------------------------------------
// demux_deser_4ch
//
// Four-channel bit-serial word assembler placed directly after a 1:4 demux.
// The demux select lines {s1,s0} choose which y line carries this cycle's
// bit. That bit is shifted into the selected channel's deserializer.
// Finished words park in a per-channel hold register. One arbiter then moves
// them onto a single valid/ready word output.
//
// Parameters:
//   WIDTH       bits per assembled word (2..16)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bit_valid   a valid data bit is present on the selected y line
//   s0, s1      demux select (channel = {s1,s0})
//   y0..y3      demux outputs; only the selected one is sampled
//   word_valid  output word available
//   word_ready  consumer accepts the output word
//   word_ch     source channel of word_data
//   word_data   assembled word; the first-received bit is the MSB
//   ovf         sticky per-channel overflow flags
//   clr_ovf     synchronous clear of all ovf bits (a same-edge set wins)
//
// Configuration macro:
//   DEMUX_DESER_RR_EN  defined   -> round-robin arbitration over the hold
//                                   registers, starting after the last grant
//                      undefined -> fixed priority, ch0 highest
// ---------------------------------------------------------------------------
module demux_deser_4ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             s0,
  input  logic             s1,
  input  logic             y0,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [1:0]       word_ch,
  output logic [WIDTH-1:0] word_data,
  output logic [3:0]       ovf,
  input  logic             clr_ovf
);

  // Bit counter width: enough bits to count up to WIDTH-1
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Per-channel deserializer state. The shift register keeps only WIDTH-1
  // bits, because the final bit of a word is taken straight from the input.
  logic [CW-1:0]    r_cnt   [4];
  logic [WIDTH-2:0] r_shReg [4];
  logic [WIDTH-1:0] r_hold  [4];
  logic [3:0]       r_full;

  logic [3:0]       w_y;
  logic [1:0]       w_sel;
  logic             w_bit;
  logic [WIDTH-1:0] w_word;
  logic             w_complete;
  logic             w_outFree;
  logic             w_grant;
  logic [1:0]       w_grantCh;
  logic [3:0]       w_drain;
  logic             w_store;
  logic             w_overflow;
  logic [3:0]       w_ovfSet;

  // Pick the selected demux output
  assign w_y   = {y3, y2, y1, y0};
  assign w_sel = {s1, s0};
  assign w_bit = w_y[w_sel];

  // Candidate word for the selected channel, with the new bit appended as LSB.
  // Its low WIDTH-1 bits are also the next shift-register content.
  assign w_word     = {r_shReg[w_sel], w_bit};
  assign w_complete = bit_valid && (r_cnt[w_sel] == LAST_BIT);

  // The output register can take a new word when it is empty or being accepted
  assign w_outFree = !word_valid || word_ready;
  assign w_grant   = w_outFree && (|r_full);
  assign w_drain   = w_grant ? (4'b0001 << w_grantCh) : 4'b0000;

  // A completed word is kept if its hold slot is empty or is emptied on this edge
  assign w_store    = w_complete && (!r_full[w_sel] || w_drain[w_sel]);
  assign w_overflow = w_complete && !w_store;
  assign w_ovfSet   = w_overflow ? (4'b0001 << w_sel) : 4'b0000;

`ifdef DEMUX_DESER_RR_EN
  // Round-robin pointer: the channel where the next search starts
  logic [1:0] r_rrPtr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= 2'd0;
    end else if (w_grant) begin
      r_rrPtr <= w_grantCh + 2'd1;
    end
  end

  // Search the four channels starting at the pointer, wrapping 3 -> 0
  always_comb begin
    logic [1:0] cand;
    logic       found;
    w_grantCh = r_rrPtr;
    found     = 1'b0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = r_rrPtr + 2'(k);
      if (!found && r_full[cand]) begin
        w_grantCh = cand;
        found     = 1'b1;
      end
    end
  end
`else
  // Fixed priority: the lowest-numbered full channel wins
  always_comb begin
    w_grantCh = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r_full[k]) begin
        w_grantCh = 2'(k);
      end
    end
  end
`endif

  // Deserializers: only the selected channel shifts and counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i]   <= '0;
        r_shReg[i] <= '0;
      end
    end else if (bit_valid) begin
      r_shReg[w_sel] <= w_word[WIDTH-2:0];
      if (w_complete) begin
        r_cnt[w_sel] <= '0;
      end else begin
        r_cnt[w_sel] <= r_cnt[w_sel] + CW'(1);
      end
    end
  end

  // Hold registers. Storing takes precedence over draining so that a drain
  // and a completion on the same channel and edge leave the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_store && (w_sel == 2'(i))) begin
          r_hold[i] <= w_word;
          r_full[i] <= 1'b1;
        end else if (w_drain[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flags: the clear is applied first, so a set on the same edge wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 4'b0000;
    end else begin
      ovf <= (clr_ovf ? 4'b0000 : ovf) | w_ovfSet;
    end
  end

  // Output register. Everything is driven from flops, so word_ready never
  // reaches the outputs combinationally; data and channel only move on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_valid <= 1'b0;
      word_ch    <= 2'd0;
      word_data  <= '0;
    end else if (w_outFree) begin
      if (w_grant) begin
        word_valid <= 1'b1;
        word_ch    <= w_grantCh;
        word_data  <= r_hold[w_grantCh];
      end else begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_deser_4ch.sv
// ---------------------------------------------------------------------------
// tb_demux_deser_4ch
//
// Self-checking bench for demux_deser_4ch with WIDTH=8. A word-level
// reference model predicts each cycle's outputs. The model keeps a running
// integer per channel, a hold slot with a full flag, and the output word.
// Directed scenarios run first, then a randomized run.
// Define DEMUX_DESER_RR_EN for both files together to test round-robin mode.
// ---------------------------------------------------------------------------
module tb_demux_deser_4ch;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bit_valid;
  logic             s0;
  logic             s1;
  logic [3:0]       yBus;
  logic             word_ready;
  logic             clr_ovf;
  logic             word_valid;
  logic [1:0]       word_ch;
  logic [WIDTH-1:0] word_data;
  logic [3:0]       ovf;

  int    checkCount = 0;
  int    passCount  = 0;
  string curTest    = "init";

  // Reference model state
  int     mAcc  [4];
  int     mCnt  [4];
  bit     mFull [4];
  int     mHold [4];
  bit     mValid;
  int     mData;
  int     mCh;
  bit [3:0] mOvf;
  int     mLast;

  demux_deser_4ch #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .s0         (s0),
    .s1         (s1),
    .y0         (yBus[0]),
    .y1         (yBus[1]),
    .y2         (yBus[2]),
    .y3         (yBus[3]),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_ch    (word_ch),
    .word_data  (word_data),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  // Clear the model to the post-reset state. Setting mLast to 3 makes ch0
  // the first channel searched.
  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mAcc[i]  = 0;
      mCnt[i]  = 0;
      mFull[i] = 1'b0;
      mHold[i] = 0;
    end
    mValid = 1'b0;
    mData  = 0;
    mCh    = 0;
    mOvf   = 4'b0000;
    mLast  = 3;
  endtask

  // Advance the model by one clock edge, using the inputs now being driven
  task automatic modelStep();
    int c;
    int g;
    int word;
    bit freeOut;
    bit done;
    c       = int'({s1, s0});
    freeOut = !mValid || word_ready;
    g       = -1;
    if (freeOut) begin
`ifdef DEMUX_DESER_RR_EN
      for (int k = 1; k <= 4; k++) begin
        int cand;
        cand = (mLast + k) % 4;
        if (g < 0 && mFull[cand]) g = cand;
      end
`else
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && mFull[k]) g = k;
      end
`endif
    end
    done = 1'b0;
    word = 0;
    if (bit_valid) begin
      mAcc[c] = mAcc[c] * 2 + int'(yBus[c]);
      mCnt[c] = mCnt[c] + 1;
      if (mCnt[c] == WIDTH) begin
        done    = 1'b1;
        word    = mAcc[c];
        mAcc[c] = 0;
        mCnt[c] = 0;
      end
    end
    if (freeOut) begin
      if (g >= 0) begin
        mValid   = 1'b1;
        mData    = mHold[g];
        mCh      = g;
        mFull[g] = 1'b0;
        mLast    = g;
      end else begin
        mValid = 1'b0;
      end
    end
    if (clr_ovf) mOvf = 4'b0000;
    if (done) begin
      if (!mFull[c]) begin
        mHold[c] = word;
        mFull[c] = 1'b1;
      end else begin
        mOvf[c] = 1'b1;
      end
    end
  endtask

  // One comparison; every call counts once toward the summary
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare every DUT output with the model
  task automatic checkOutput();
    checkVal({curTest, "/valid"}, 32'(word_valid), 32'(mValid));
    checkVal({curTest, "/ch"},    32'(word_ch),    32'(mCh));
    checkVal({curTest, "/data"},  32'(word_data),  32'(mData));
    checkVal({curTest, "/ovf"},   32'(ovf),        32'(mOvf));
  endtask

  // Drive one cycle of inputs. Unselected y lines get random noise. Run the
  // model, let the edge happen, then check on the falling edge.
  task automatic applyStimulus(input bit bv, input int ch, input bit b, input bit rdy, input bit clr);
    bit_valid  = bv;
    {s1, s0}   = 2'(ch);
    yBus       = 4'($urandom);
    yBus[ch]   = b;
    word_ready = rdy;
    clr_ovf    = clr;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic sendWord(input int ch, input logic [7:0] w, input bit rdy);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(1'b1, ch, w[i], rdy, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] wa;
    logic [7:0] wb;
    int expD [4];
    int expC [4];

    rst_n      = 1'b0;
    bit_valid  = 1'b0;
    s0         = 1'b0;
    s1         = 1'b0;
    yBus       = 4'b0000;
    word_ready = 1'b0;
    clr_ovf    = 1'b0;
    modelReset();

    // Reset state
    curTest = "reset";
    repeat (2) @(negedge clk);
    checkOutput();
    rst_n = 1'b1;

    // Single word on ch2: word_valid rises 2 edges after the last bit
    curTest = "single";
    sendWord(2, 8'hA5, 1'b1);
    checkVal("single/notYet", 32'(word_valid), 32'd0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkVal("single/valid", 32'(word_valid), 32'd1);
    checkVal("single/ch",    32'(word_ch),    32'd2);
    checkVal("single/data",  32'(word_data),  32'hA5);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkVal("single/pulse", 32'(word_valid), 32'd0);

    // Bit-by-bit interleave of ch0 and ch1
    curTest = "interleave";
    wa = 8'h3C;
    wb = 8'hC3;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(1'b1, 0, wa[i], 1'b1, 1'b0);
      applyStimulus(1'b1, 1, wb[i], 1'b1, 1'b0);
    end
    checkVal("interleave/ch0",   32'(word_ch),   32'd0);
    checkVal("interleave/data0", 32'(word_data), 32'h3C);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkVal("interleave/ch1",   32'(word_ch),   32'd1);
    checkVal("interleave/data1", 32'(word_data), 32'hC3);
    checkVal("interleave/ovf",   32'(ovf),       32'd0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Backpressure: the third word overflows ch3 and is never output
    curTest = "backpressure";
    sendWord(3, 8'h11, 1'b0);
    sendWord(3, 8'h22, 1'b0);
    sendWord(3, 8'h33, 1'b0);
    checkVal("backpressure/heldData", 32'(word_data), 32'h11);
    checkVal("backpressure/ovf",      32'(ovf),       32'h8);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkVal("backpressure/second", 32'(word_data), 32'h22);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkVal("backpressure/dropped", 32'(word_valid), 32'd0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Async reset while a word is pending and ch1 is mid-word
    curTest = "resetMid";
    sendWord(0, 8'h77, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1, 1'($urandom), 1'b0, 1'b0);
    end
    bit_valid = 1'b0;
    rst_n     = 1'b0;
    modelReset();
    #1;
    checkVal("resetMid/valid", 32'(word_valid), 32'd0);
    checkVal("resetMid/data",  32'(word_data),  32'd0);
    checkVal("resetMid/ch",    32'(word_ch),    32'd0);
    checkVal("resetMid/ovf",   32'(ovf),        32'd0);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput();
    sendWord(1, 8'h5A, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkVal("resetMid/ch1",   32'(word_ch),   32'd1);
    checkVal("resetMid/fresh", 32'(word_data), 32'h5A);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Arbitration: ch0 is granted first, then refilled behind ch1..ch3
    curTest = "arbitration";
    sendWord(0, 8'h10, 1'b0);
    sendWord(1, 8'h11, 1'b0);
    sendWord(2, 8'h12, 1'b0);
    sendWord(3, 8'h13, 1'b0);
    sendWord(0, 8'h20, 1'b0);
    checkVal("arbitration/first", 32'(word_data), 32'h10);
`ifdef DEMUX_DESER_RR_EN
    expD = '{'h11, 'h12, 'h13, 'h20};
    expC = '{1, 2, 3, 0};
`else
    expD = '{'h20, 'h11, 'h12, 'h13};
    expC = '{0, 1, 2, 3};
`endif
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
      checkVal("arbitration/orderData", 32'(word_data), 32'(expD[k]));
      checkVal("arbitration/orderCh",   32'(word_ch),   32'(expC[k]));
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkVal("arbitration/empty", 32'(word_valid), 32'd0);

    // Clear racing a fresh overflow on ch0: the set wins
    curTest = "ovfRace";
    sendWord(0, 8'hA1, 1'b0);
    sendWord(0, 8'hA2, 1'b0);
    sendWord(0, 8'hA3, 1'b0);
    checkVal("ovfRace/set", 32'(ovf), 32'h1);
    wa = 8'hA4;
    for (int i = WIDTH - 1; i >= 1; i--) begin
      applyStimulus(1'b1, 0, wa[i], 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 0, wa[0], 1'b0, 1'b1);
    checkVal("ovfRace/setWins", 32'(ovf), 32'h1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    checkVal("ovfRace/cleared", 32'(ovf), 32'h0);
    repeat (3) applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with random backpressure and occasional clears
    curTest = "random";
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom % 8) != 0, int'($urandom % 4), 1'($urandom),
                    ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
    repeat (6) applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
